// File: rtl/fetch_unit.sv
// Fetch stage of the 3-stage RV32I pipeline: PC, synchronous IMEM addressing,
// FD->X register with wrong-path squash. Optional counters under FETCH_STATS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jal_target,
  input  logic [31:0] alu_target,
  input  logic        is_j_or_b,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_fd,
  output logic [31:0] inst_fd,
  output logic        valid_fd,
  output logic [31:0] pc_x,
  output logic [31:0] inst_x,
  output logic        valid_x
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] squash_count
`endif
);

  logic [31:0] pc_q, pc_d;
  logic        valid_fd_q, valid_fd_d;
  logic [31:0] pc_x_q, pc_x_d;
  logic [31:0] inst_x_q, inst_x_d;
  logic        valid_x_q, valid_x_d;
  logic        redirect;

  assign redirect = (pc_sel == 2'd1) && is_j_or_b;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect)                    pc_d = {alu_target[31:2], 2'b00};
    else if (stall || !valid_fd_q)   pc_d = pc_q;
    else if (pc_sel == 2'd0)         pc_d = {jal_target[31:2], 2'b00};
  end

  // The data returned after a redirect belongs to the new target, so FD stays valid.
  assign valid_fd_d = 1'b1;

  assign imem_addr = rst_n ? pc_d : RESET_PC;
  assign pc_fd     = pc_q;
  assign valid_fd  = valid_fd_q;
  assign inst_fd   = valid_fd_q ? imem_rdata : NOP_INST;

  always_comb begin
    pc_x_d    = pc_x_q;
    inst_x_d  = inst_x_q;
    valid_x_d = valid_x_q;
    if (redirect) begin
      inst_x_d  = NOP_INST;
      valid_x_d = 1'b0;
    end else if (!stall) begin
      pc_x_d    = pc_q;
      inst_x_d  = inst_fd;
      valid_x_d = valid_fd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      valid_fd_q <= 1'b0;
      pc_x_q     <= 32'd0;
      inst_x_q   <= NOP_INST;
      valid_x_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      valid_fd_q <= valid_fd_d;
      pc_x_q     <= pc_x_d;
      inst_x_q   <= inst_x_d;
      valid_x_q  <= valid_x_d;
    end
  end

  assign pc_x    = pc_x_q;
  assign inst_x  = inst_x_q;
  assign valid_x = valid_x_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] squash_count_q, squash_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    squash_count_d = squash_count_q;
    if (valid_fd_q && !stall && !redirect) fetch_count_d  = fetch_count_q + 32'd1;
    if (valid_fd_q && redirect)            squash_count_d = squash_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= 32'd0;
      squash_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign squash_count = squash_count_q;
`endif

endmodule
